wb_regfile: RTL and testbench

- Write-back end of the MEM/WB pipeline interface. Consumes the MEM/WB register outputs and selects the write-back destination and data.
- Owns the 32x32 general-purpose register file: commits on clk, serves ID-stage reads with same-cycle write-through bypass.
- Exports the current write-back (en, addr, data) for the forwarding unit.

---
 rtl/wb_regfile_if.sv | 34 +++
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus plus the ID-stage read ports and forwarding export of the register file.
// The master drives the pipeline and address fields. The slave (the register file) drives the data and forwarding fields.
interface wb_regfile_if;
   logic [31:0] IR_wb;
   logic [31:0] PC_plus_4_wb;
   logic [31:0] Mem_data_wb;
   logic [31:0] ALU_out_wb;
   logic        RegWrite_wb;
   logic [1:0]  RegDst_wb;
   logic [1:0]  MemtoReg_wb;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   modport master (
      output IR_wb, PC_plus_4_wb, Mem_data_wb, ALU_out_wb,
      output RegWrite_wb, RegDst_wb, MemtoReg_wb,
      output rs_addr, rt_addr, dbg_addr,
      input  rs_data, rt_data, wb_en, wb_addr, wb_data, dbg_data
   );

   modport slave (
      input  IR_wb, PC_plus_4_wb, Mem_data_wb, ALU_out_wb,
      input  RegWrite_wb, RegDst_wb, MemtoReg_wb,
      input  rs_addr, rt_addr, dbg_addr,
      output rs_data, rt_data, wb_en, wb_addr, wb_data, dbg_data
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 general-purpose register file.
// Read ports see same-cycle write-back data through a bypass. The debug port sees committed state only.
module wb_regfile #(
   parameter logic [31:0] SP_INIT = 32'h7fffeffc,
   parameter logic [31:0] GP_INIT = 32'h10008000
) (
   input  logic        clk,
   input  logic        reset,
   wb_regfile_if.slave bus
);
   logic [31:0] regs [0:31];
   logic [4:0]  wb_addr_sel;
   logic [31:0] wb_data_sel;
   logic        wb_en_sel;

   always_comb begin
      case (bus.RegDst_wb)
         2'b01:   wb_addr_sel = bus.IR_wb[15:11];
         2'b10:   wb_addr_sel = 5'd31;
         default: wb_addr_sel = bus.IR_wb[20:16];
      endcase
   end

   always_comb begin
      case (bus.MemtoReg_wb)
         2'b01:   wb_data_sel = bus.Mem_data_wb;
         2'b10:   wb_data_sel = bus.PC_plus_4_wb;
         default: wb_data_sel = bus.ALU_out_wb;
      endcase
   end

   // $0 is hardwired. Suppressing the enable here also keeps it out of the forwarding path.
   assign wb_en_sel   = bus.RegWrite_wb && (wb_addr_sel != 5'd0);
   assign bus.wb_en   = wb_en_sel;
   assign bus.wb_addr = wb_addr_sel;
   assign bus.wb_data = wb_data_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
         regs[28] <= GP_INIT;
         regs[29] <= SP_INIT;
      end else if (wb_en_sel) begin
         regs[wb_addr_sel] <= wb_data_sel;
      end
   end

   function automatic logic [31:0] read_port(
      input logic [4:0]  addr,
      input logic [31:0] stored,
      input logic        en,
      input logic [4:0]  waddr,
      input logic [31:0] wdata
   );
      if (addr == 5'd0) begin
         return 32'd0;
      end else if (en && (addr == waddr)) begin
         return wdata;
      end
      return stored;
   endfunction

   assign bus.rs_data  = read_port(bus.rs_addr, regs[bus.rs_addr], wb_en_sel, wb_addr_sel, wb_data_sel);
   assign bus.rt_data  = read_port(bus.rt_addr, regs[bus.rt_addr], wb_en_sel, wb_addr_sel, wb_data_sel);
   assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs[bus.dbg_addr];
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a behavioural register-file model is compared every cycle.
// It also runs directed literal checks from the test plan, followed by randomized write-back traffic.
module tb_wb_regfile;
   localparam logic [31:0] SP_INIT = 32'h7fffeffc;
   localparam logic [31:0] GP_INIT = 32'h10008000;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          run_cmp  = 1'b0;
   logic [31:0] model [32];

   wb_regfile_if bus ();

   wb_regfile #(
      .SP_INIT (SP_INIT),
      .GP_INIT (GP_INIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: destination and data taken directly from the select rules, with a plain array as storage.
   function automatic logic [4:0] m_dest();
      if (bus.RegDst_wb == 2'b01) return bus.IR_wb[15:11];
      if (bus.RegDst_wb == 2'b10) return 5'd31;
      return bus.IR_wb[20:16];
   endfunction

   function automatic logic [31:0] m_data();
      if (bus.MemtoReg_wb == 2'b01) return bus.Mem_data_wb;
      if (bus.MemtoReg_wb == 2'b10) return bus.PC_plus_4_wb;
      return bus.ALU_out_wb;
   endfunction

   function automatic logic m_en();
      return bus.RegWrite_wb && (m_dest() != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_en() && (a == m_dest())) return m_data();
      return model[a];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] <= 32'd0;
         model[28] <= GP_INIT;
         model[29] <= SP_INIT;
      end else if (m_en()) begin
         model[m_dest()] <= m_data();
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("wb_en",    {31'd0, bus.wb_en},   {31'd0, m_en()});
         chk("wb_addr",  {27'd0, bus.wb_addr}, {27'd0, m_dest()});
         chk("wb_data",  bus.wb_data, m_data());
         chk("rs_data",  bus.rs_data, m_read(bus.rs_addr));
         chk("rt_data",  bus.rt_data, m_read(bus.rt_addr));
         chk("dbg_data", bus.dbg_data, (bus.dbg_addr == 5'd0) ? 32'd0 : model[bus.dbg_addr]);
      end
   end

   task automatic drive(input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] mem,
                        input logic [31:0] alu, input logic rw, input logic [1:0] rd,
                        input logic [1:0] mt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dbg);
      @(posedge clk);
      #1;
      bus.IR_wb        = ir;
      bus.PC_plus_4_wb = pc4;
      bus.Mem_data_wb  = mem;
      bus.ALU_out_wb   = alu;
      bus.RegWrite_wb  = rw;
      bus.RegDst_wb    = rd;
      bus.MemtoReg_wb  = mt;
      bus.rs_addr      = rs;
      bus.rt_addr      = rt;
      bus.dbg_addr     = dbg;
      $display("txn t=%0t ir=%h rw=%0d rd=%0d mt=%0d rs=%0d rt=%0d dbg=%0d",
               $time, ir, rw, rd, mt, rs, rt, dbg);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input logic [4:0] dbg);
      drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, dbg);
   endtask

   initial begin
      bus.IR_wb = '0; bus.PC_plus_4_wb = '0; bus.Mem_data_wb = '0; bus.ALU_out_wb = '0;
      bus.RegWrite_wb = 1'b0; bus.RegDst_wb = '0; bus.MemtoReg_wb = '0;
      bus.rs_addr = '0; bus.rt_addr = '0; bus.dbg_addr = '0;
      run_cmp = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset image of the register file
      for (int i = 0; i < 32; i++) begin
         logic [31:0] exp_v;
         exp_v = (i == 28) ? 32'h10008000 : (i == 29) ? 32'h7fffeffc : 32'd0;
         idle(5'(i));
         settle();
         chk("reset_dbg", bus.dbg_data, exp_v);
      end

      // R-type add $8: bypass on both ports in the write cycle, committed afterwards
      drive(32'h012A4020, 32'd0, 32'h12345678, 32'h00000055, 1'b1, 2'b01, 2'b00, 5'd8, 5'd8, 5'd8);
      settle();
      chk("rtype_addr", {27'd0, bus.wb_addr}, 32'd8);
      chk("rtype_rs_bypass", bus.rs_data, 32'h55);
      chk("rtype_rt_bypass", bus.rt_data, 32'h55);
      chk("rtype_dbg_nobypass", bus.dbg_data, 32'd0);
      idle(5'd8);
      settle();
      chk("rtype_commit", bus.dbg_data, 32'h55);

      // lw $9: memory data wins over ALU result
      drive(32'h8D090004, 32'd0, 32'hDEADBEEF, 32'h00000104, 1'b1, 2'b00, 2'b01, 5'd9, 5'd0, 5'd9);
      settle();
      chk("load_addr", {27'd0, bus.wb_addr}, 32'd9);
      chk("load_data", bus.wb_data, 32'hDEADBEEF);
      idle(5'd9);
      settle();
      chk("load_commit", bus.dbg_data, 32'hDEADBEEF);

      // jal link to $31
      drive(32'h0C100000, 32'h0040000C, 32'h0, 32'h0, 1'b1, 2'b10, 2'b10, 5'd31, 5'd0, 5'd0);
      settle();
      chk("jal_addr", {27'd0, bus.wb_addr}, 32'd31);
      chk("jal_rs_bypass", bus.rs_data, 32'h0040000C);
      idle(5'd31);
      settle();
      chk("jal_commit", bus.dbg_data, 32'h0040000C);

      // $0 protection, then a disabled write to $5
      drive(32'h00000000, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 5'd0);
      settle();
      chk("zero_en", {31'd0, bus.wb_en}, 32'd0);
      chk("zero_rs", bus.rs_data, 32'd0);
      chk("zero_wbdata", bus.wb_data, 32'hFFFFFFFF);
      drive(32'h00002820, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 2'b01, 2'b00, 5'd5, 5'd0, 5'd0);
      settle();
      chk("zero_dbg", bus.dbg_data, 32'd0);
      chk("nowrite_rs", bus.rs_data, 32'd0);
      idle(5'd5);
      settle();
      chk("nowrite_commit", bus.dbg_data, 32'd0);

      // Reset coincident with a write edge discards the write
      drive(32'h00030000, 32'd0, 32'd0, 32'd7, 1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 5'd3);
      drive(32'h00030000, 32'd0, 32'd0, 32'd9, 1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 5'd3);
      settle();
      chk("collide_pre", bus.dbg_data, 32'd7);
      @(posedge clk);
      reset = 1'b1;
      #1 bus.RegWrite_wb = 1'b0;
      settle();
      chk("collide_reset", bus.dbg_data, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      drive(32'h00030000, 32'd0, 32'd0, 32'd9, 1'b1, 2'b00, 2'b00, 5'd3, 5'd0, 5'd3);
      idle(5'd3);
      settle();
      chk("collide_after", bus.dbg_data, 32'd9);

      // Randomized traffic with read ports biased onto the write destination
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk);
         #1;
         bus.IR_wb        = $urandom;
         bus.PC_plus_4_wb = $urandom;
         bus.Mem_data_wb  = $urandom;
         bus.ALU_out_wb   = $urandom;
         bus.RegWrite_wb  = ($urandom_range(0, 3) != 0);
         bus.RegDst_wb    = 2'($urandom_range(0, 3));
         bus.MemtoReg_wb  = 2'($urandom_range(0, 3));
         bus.rs_addr      = ($urandom_range(0, 2) == 0) ? m_dest() : 5'($urandom);
         bus.rt_addr      = ($urandom_range(0, 2) == 0) ? m_dest() : 5'($urandom_range(0, 7));
         bus.dbg_addr     = ($urandom_range(0, 1) == 0) ? m_dest() : 5'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            #2 reset = 1'b1;
            #1 reset = 1'b0;
            $display("txn t=%0t mid-stream reset pulse", $time);
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
